// File: rtl/mod_reduce_128.sv
// mod_reduce_128: reduces a 2*DATA_WIDTH-bit product modulo a DATA_WIDTH-bit
// modulus with a bit-serial restoring shift-subtract loop, MSB first, one
// product bit per cycle. A zero modulus is flagged through output_error.
module mod_reduce_128 #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*DATA_WIDTH-1:0] input_tdata,
  input  logic [DATA_WIDTH-1:0]   modulus_tdata,
  input  logic                    input_tvalid,
  output logic                    input_tready,
  output logic [DATA_WIDTH-1:0]   output_tdata,
  output logic                    output_error,
  output logic                    output_tvalid,
  input  logic                    output_tready
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(PW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state;
  logic [PW-1:0]         prod;
  logic [DATA_WIDTH-1:0] m;
  logic [DATA_WIDTH-1:0] rem;
  logic [CW-1:0]         cnt;

  logic [DATA_WIDTH:0]   trial;
  logic                  ge;
  logic [DATA_WIDTH-1:0] rem_nxt;

  // One restoring step. The true difference is always < m, so it fits in
  // DATA_WIDTH bits and the low-bit subtraction is exact.
  always_comb begin
    trial   = {rem, prod[cnt]};
    ge      = (trial >= {1'b0, m});
    rem_nxt = ge ? (trial[DATA_WIDTH-1:0] - m) : trial[DATA_WIDTH-1:0];
  end

  // Accept only in IDLE and never while reset is asserted.
  assign input_tready = (state == IDLE) && !rst;

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      prod          <= '0;
      m             <= '0;
      rem           <= '0;
      cnt           <= '0;
      output_tdata  <= '0;
      output_error  <= 1'b0;
      output_tvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (input_tvalid) begin
            prod <= input_tdata;
            m    <= modulus_tdata;
            if (modulus_tdata == '0) begin
              output_tdata  <= '0;
              output_error  <= 1'b1;
              output_tvalid <= 1'b1;
              state         <= DONE;
            end else begin
              rem   <= '0;
              cnt   <= CW'(PW - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            output_tdata  <= rem_nxt;
            output_error  <= 1'b0;
            output_tvalid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          // Result is held until the consumer takes it.
          if (output_tready) begin
            output_tvalid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_reduce_128.sv
// Directed bench for mod_reduce_128: hand-computed remainders, latency,
// back-pressure hold, zero modulus and mid-operation reset.
module tb_mod_reduce_128;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] input_tdata;
  logic [63:0]  modulus_tdata;
  logic         input_tvalid;
  logic         input_tready;
  logic [63:0]  output_tdata;
  logic         output_error;
  logic         output_tvalid;
  logic         output_tready;

  int checks = 0;
  int errors = 0;

  mod_reduce_128 #(.DATA_WIDTH(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .input_tdata   (input_tdata),
    .modulus_tdata (modulus_tdata),
    .input_tvalid  (input_tvalid),
    .input_tready  (input_tready),
    .output_tdata  (output_tdata),
    .output_error  (output_error),
    .output_tvalid (output_tvalid),
    .output_tready (output_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one reduction, measure latency, hold output for 'hold' cycles,
  // then complete the handshake and confirm return to IDLE.
  task automatic run_op(input string tag, input logic [127:0] prod, input logic [63:0] p,
                        input logic [63:0] exp_data, input logic exp_err,
                        input int exp_lat, input int hold);
    int lat;
    int wait_c;
    wait_c = 0;
    while (!input_tready && wait_c < 300) begin
      tick();
      wait_c++;
    end
    chk({tag, ".rdy"}, 64'(input_tready), 64'd1);
    input_tdata   = prod;
    modulus_tdata = p;
    input_tvalid  = 1'b1;
    tick();                       // acceptance edge
    input_tvalid  = 1'b0;
    input_tdata   = '0;
    modulus_tdata = '0;
    chk({tag, ".busy"}, 64'(input_tready), 64'd0);
    lat = 0;                      // edges after the acceptance edge
    while (!output_tvalid && lat < 300) begin
      tick();
      lat++;
    end
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".data"}, output_tdata, exp_data);
    chk({tag, ".err"}, 64'(output_error), 64'(exp_err));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, ".hold_v"}, 64'(output_tvalid), 64'd1);
      chk({tag, ".hold_d"}, output_tdata, exp_data);
      chk({tag, ".hold_r"}, 64'(input_tready), 64'd0);
    end
    output_tready = 1'b1;
    tick();                       // output handshake edge
    output_tready = 1'b0;
    chk({tag, ".v_drop"}, 64'(output_tvalid), 64'd0);
    chk({tag, ".idle"}, 64'(input_tready), 64'd1);
  endtask

  initial begin
    rst           = 1'b1;
    input_tdata   = '0;
    modulus_tdata = '0;
    input_tvalid  = 1'b0;
    output_tready = 1'b0;
    tick();
    chk("rst.rdy", 64'(input_tready), 64'd0);
    chk("rst.v", 64'(output_tvalid), 64'd0);
    chk("rst.d", output_tdata, 64'd0);
    chk("rst.e", 64'(output_error), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst.rdy", 64'(input_tready), 64'd1);

    // 100 mod 7 = 2
    run_op("t1", 128'd100, 64'd7, 64'd2, 1'b0, 128, 0);
    // (2^128-1) mod (2^64-1) = 0
    run_op("t2", {128{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 128, 0);
    // (p-1)^2 mod p = 1
    run_op("t3", 128'hFFFF_FFFF_FFFF_FF88_0000_0000_0000_0E10,
           64'hFFFF_FFFF_FFFF_FFC5, 64'd1, 1'b0, 128, 0);
    // zero modulus: error, result valid right after acceptance
    run_op("t4z", 128'h1234_5678, 64'd0, 64'd0, 1'b1, 0, 0);
    run_op("t4n", 128'd100, 64'd7, 64'd2, 1'b0, 128, 0);
    // back-pressure for 10 cycles: 1000 mod 9 = 1
    run_op("t5", 128'd1000, 64'd9, 64'd1, 1'b0, 128, 10);
    // product < p returned unchanged; p == 1 gives 0
    run_op("lt", 128'd5, 64'd1000, 64'd5, 1'b0, 128, 0);
    run_op("p1", 128'hDEAD_BEEF_0000_0001, 64'd1, 64'd0, 1'b0, 128, 0);

    // reset in the middle of CALC abandons the operation
    input_tdata   = 128'd99999;
    modulus_tdata = 64'd7;
    input_tvalid  = 1'b1;
    tick();
    input_tvalid  = 1'b0;
    repeat (50) tick();
    rst = 1'b1;
    tick();
    chk("t6.rst_rdy", 64'(input_tready), 64'd0);
    chk("t6.rst_v", 64'(output_tvalid), 64'd0);
    chk("t6.rst_d", output_tdata, 64'd0);
    chk("t6.rst_e", 64'(output_error), 64'd0);
    rst = 1'b0;
    #1;
    chk("t6.idle", 64'(input_tready), 64'd1);
    repeat (130) tick();
    chk("t6.no_result", 64'(output_tvalid), 64'd0);
    run_op("t6", 128'd12345, 64'd1000, 64'd345, 1'b0, 128, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
